// File: rtl/vpu_pkg.sv
// Shared opcodes, FSM state type and result clamp/truncate helper for the lane vector unit.
// Saturating arithmetic is selected at build time with the VPU_SAT_EN macro.
package vpu_pkg;

`ifdef VPU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [5:0] OP_ADD  = 6'd2;
    localparam logic [5:0] OP_MOVE = 6'd3;
    localparam logic [5:0] OP_RELU = 6'd4;
    localparam logic [5:0] OP_SMUL = 6'd5;
    localparam logic [5:0] OP_SUB  = 6'd6;
    localparam logic [5:0] OP_MAX  = 6'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DONE
    } state_t;

    function automatic bit op_legal(input logic [5:0] op);
        return (op >= OP_ADD) && (op <= OP_MAX);
    endfunction

    // Clamps v to a w-bit signed range when sat is set; the caller keeps the low w bits.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] v,
                                                     input int w, input bit sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (sat && (v > hi)) return hi;
        if (sat && (v < lo)) return lo;
        return v;
    endfunction

endpackage

// File: rtl/vpu_lane.sv
// Single-element signed ALU, purely combinational (zero latency, no flow control).
// Disabled lanes output zero; saturation follows VPU_SAT_EN via vpu_pkg::SAT_EN.
module vpu_lane
    import vpu_pkg::*;
#(
    parameter int NUM_SIZE = 16
) (
    input  logic [5:0]                 opcode,
    input  logic signed [NUM_SIZE-1:0] a,
    input  logic signed [NUM_SIZE-1:0] b,
    input  logic signed [NUM_SIZE-1:0] scalar,
    input  logic                       en,
    output logic [NUM_SIZE-1:0]        result
);

    logic signed [63:0]   wide;
    logic [NUM_SIZE-1:0]  clamped;

    always_comb begin
        wide = '0;
        case (opcode)
            OP_ADD:  wide = 64'(a) + 64'(b);
            OP_SUB:  wide = 64'(a) - 64'(b);
            OP_SMUL: wide = 64'(scalar) * 64'(a);
            OP_MOVE: wide = 64'(a);
            OP_RELU: wide = (a > 0) ? 64'(a) : 64'sd0;
            OP_MAX:  wide = (a > b) ? 64'(a) : 64'(b);
            default: wide = '0;
        endcase
        // MOVE/RELU/MAX are always in range, so clamping them is a no-op.
        clamped = NUM_SIZE'(sat_trunc(wide, NUM_SIZE, SAT_EN));
        result  = en ? clamped : '0;
    end

endmodule

// File: rtl/vpu_lanes.sv
// Multi-beat vector unit: LANES elements per beat, first beat valid the cycle after start.
// Beats held stable while wb_ready is low; start is ignored until back in IDLE. Macro: VPU_SAT_EN.
module vpu_lanes
    import vpu_pkg::*;
#(
    parameter  int NUM_SIZE        = 16,
    parameter  int WORDS_IN_MEMORY = 32,
    parameter  int LANES           = 4,
    parameter  int MAX_LEN         = 16,
    localparam int ADDR_W          = $clog2(WORDS_IN_MEMORY),
    localparam int LEN_W           = $clog2(MAX_LEN + 1) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SIZE*WORDS_IN_MEMORY-1:0] flat_memory,
    input  logic [5:0]                    opcode,
    input  logic [ADDR_W-1:0]             src_a,
    input  logic [ADDR_W-1:0]             src_b,
    input  logic [ADDR_W-1:0]             dest,
    input  logic [LEN_W-1:0]              length,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [ADDR_W-1:0]             wb_addr,
    output logic [LANES*NUM_SIZE-1:0]     wb_data,
    output logic [LANES-1:0]              wb_mask
);

    state_t                state, state_nxt;
    logic [5:0]            op_q;
    logic [ADDR_W-1:0]     src_a_q, src_b_q, dest_q;
    logic [LEN_W-1:0]      len_q, beat_q;
    logic [NUM_SIZE-1:0]   scalar_q;
    logic                  err_q;

    logic                  req_bad, hs, last_beat, load;
    logic [5:0]            sel_op;
    logic [ADDR_W-1:0]     sel_src_a, sel_src_b, sel_dest;
    logic [LEN_W-1:0]      sel_len, sel_beat;
    logic [NUM_SIZE-1:0]   sel_scalar;
    logic [ADDR_W-1:0]     beat_addr;
    logic [LANES*NUM_SIZE-1:0] beat_data;
    logic [LANES-1:0]      beat_mask;

    assign req_bad   = !op_legal(opcode) || (length > LEN_W'(MAX_LEN));
    assign hs        = (state == ST_STREAM) && wb_ready;
    assign last_beat = ((32'(beat_q) + 32'd1) * 32'(LANES)) >= 32'(len_q);
    assign load      = ((state == ST_IDLE) && start && !req_bad && (length != '0))
                     || (hs && !last_beat);

    // In IDLE the first beat is computed straight from the request; afterwards from the latches.
    always_comb begin
        if (state == ST_IDLE) begin
            sel_op     = opcode;
            sel_src_a  = src_a;
            sel_src_b  = src_b;
            sel_dest   = dest;
            sel_len    = length;
            sel_beat   = '0;
            sel_scalar = flat_memory[32'(src_b)*NUM_SIZE +: NUM_SIZE];
        end else begin
            sel_op     = op_q;
            sel_src_a  = src_a_q;
            sel_src_b  = src_b_q;
            sel_dest   = dest_q;
            sel_len    = len_q;
            sel_beat   = beat_q + LEN_W'(1);
            sel_scalar = scalar_q;
        end
    end

    assign beat_addr = ADDR_W'(32'(sel_dest) + 32'(sel_beat) * 32'(LANES));

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [31:0]       elem;
        logic [ADDR_W-1:0] a_idx, b_idx;
        assign elem         = 32'(sel_beat) * 32'(LANES) + 32'(j);
        assign a_idx        = ADDR_W'(32'(sel_src_a) + elem);
        assign b_idx        = ADDR_W'(32'(sel_src_b) + elem);
        assign beat_mask[j] = elem < 32'(sel_len);

        vpu_lane #(.NUM_SIZE(NUM_SIZE)) u_lane (
            .opcode (sel_op),
            .a      (flat_memory[32'(a_idx)*NUM_SIZE +: NUM_SIZE]),
            .b      (flat_memory[32'(b_idx)*NUM_SIZE +: NUM_SIZE]),
            .scalar (sel_scalar),
            .en     (beat_mask[j]),
            .result (beat_data[j*NUM_SIZE +: NUM_SIZE])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (req_bad || (length == '0)) state_nxt = ST_DONE;
                    else                           state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: if (hs && last_beat) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        wb_valid = (state == ST_STREAM);
        done     = (state == ST_DONE);
        err      = (state == ST_DONE) && err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dest_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            scalar_q <= '0;
            err_q    <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_mask  <= '0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                op_q     <= opcode;
                src_a_q  <= src_a;
                src_b_q  <= src_b;
                dest_q   <= dest;
                len_q    <= length;
                beat_q   <= '0;
                scalar_q <= sel_scalar;
                err_q    <= req_bad;
            end else if (hs && !last_beat) begin
                beat_q <= beat_q + LEN_W'(1);
            end
            if (load) begin
                wb_addr <= beat_addr;
                wb_data <= beat_data;
                wb_mask <= beat_mask;
            end
        end
    end

endmodule
